// File: rtl/parity_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : parity_word_packer
// Description : Collects the 1-bit result of the upstream 4-input odd-parity
//               block, one bit per accepted cycle, and packs the bits
//               LSB-first into WORD_W-bit words. Each word is presented on a
//               single-entry valid/ready output register. A flush request
//               emits a partial word; if the output slot is busy the flush
//               is remembered and executed on the first free cycle.
//               Optional feature macro: PARITY_ERRCNT_EN adds a saturating
//               16-bit count of accepted 1-bits on err_count.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_word_packer #(
  parameter  int WORD_W = 8,                  // bits per word, 2..32
  localparam int CW     = $clog2(WORD_W + 1)  // width of out_count
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [CW-1:0]     out_count
`ifdef PARITY_ERRCNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  // Bit count at which the accumulator holds a complete word.
  localparam logic [CW-1:0] c_full = CW'(WORD_W);

  // Accumulator state
  logic [WORD_W-1:0] r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_flush_pend;

  // Output register state
  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_word;
  logic [CW-1:0]     r_out_count;

  // Combinational helpers
  logic              w_in_ready;
  logic              w_fire_in;
  logic              w_slot_free;
  logic              w_want_flush;
  logic              w_transfer;
  logic [WORD_W-1:0] w_nxt_acc;
  logic [CW-1:0]     w_nxt_cnt;
  logic [WORD_W-1:0] w_mask;
  logic              w_nxt_nonempty;

  // Handshake terms. A full accumulator can only exist while the output slot
  // is blocked, so in_ready simply reflects whether there is room left.
  assign w_in_ready     = (r_cnt < c_full);
  assign w_fire_in      = in_valid & w_in_ready;
  assign w_slot_free    = ~r_out_valid | out_ready;
  assign w_want_flush   = flush | r_flush_pend;
  assign w_nxt_cnt      = r_cnt + {{(CW-1){1'b0}}, w_fire_in};
  assign w_nxt_nonempty = (w_nxt_cnt != '0);
  assign w_transfer     = w_slot_free &
                          ((w_nxt_cnt == c_full) | (w_want_flush & w_nxt_nonempty));

  // Insert the accepted bit at position r_cnt and build the valid-bit mask.
  // The compare-per-bit form avoids indexing with the wider count register.
  always_comb begin
    w_nxt_acc = r_acc;
    w_mask    = '0;
    for (int i = 0; i < WORD_W; i++) begin
      if (w_fire_in && (r_cnt == CW'(i))) begin
        w_nxt_acc[i] = in_bit;
      end
      w_mask[i] = (CW'(i) < w_nxt_cnt);
    end
  end

  // Accumulator, bit count and sticky flush request.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else if (w_transfer) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_acc        <= w_nxt_acc;
      r_cnt        <= w_nxt_cnt;
      // A flush against an empty accumulator is dropped rather than kept.
      r_flush_pend <= w_want_flush & w_nxt_nonempty;
    end
  end

  // Single-entry output register; word and count only change on a transfer,
  // which keeps them stable while the consumer applies backpressure.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_count <= '0;
    end else if (w_transfer) begin
      r_out_valid <= 1'b1;
      // Bits above the count are cleared so partial words are zero-padded.
      r_out_word  <= w_nxt_acc & w_mask;
      r_out_count <= w_nxt_cnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign out_count = r_out_count;

`ifdef PARITY_ERRCNT_EN
  logic [15:0] r_err_cnt;

  // Saturating count of accepted 1-bits (odd-parity / error indications).
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_err_cnt <= '0;
    end else if (w_fire_in && in_bit && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parity_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_word_packer
// Description : Directed self-checking bench for parity_word_packer with
//               WORD_W = 8. Covers reset, full-rate packing, backpressure,
//               flush (immediate, pending, empty) and reset mid-word.
//               Define PARITY_ERRCNT_EN to also exercise err_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_word_packer;

  localparam int WORD_W = 8;
  localparam int CW     = $clog2(WORD_W + 1);

  logic              clk = 1'b0;
  logic              areset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_bit = 1'b0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WORD_W-1:0] out_word;
  logic [CW-1:0]     out_count;
`ifdef PARITY_ERRCNT_EN
  logic [15:0]       err_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  parity_word_packer #(.WORD_W(WORD_W)) dut (
    .clk       (clk),
    .areset    (areset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_count (out_count)
`ifdef PARITY_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  // Free-running clock, 10 time units period.
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present n bits (LSB of 'bits' first), one per cycle, checking the
  // packer is ready for each of them.
  task automatic send_bits(input string tag, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = bits[i];
      #1;
      check($sformatf("%s_rdy%0d", tag, i), {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  initial begin
    // ---- 1. asynchronous reset, no clock edge yet -----------------------
    #3 areset = 1'b1;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_word",  {24'd0, out_word},  32'd0);
    check("rst_count", {28'd0, out_count}, 32'd0);
    check("rst_ready", {31'd0, in_ready},  32'd1);
    tick();
    areset = 1'b0;
    tick();

    // ---- 2. full-rate packing, bits 1,0,1,1,0,0,0,1 -> 0x8D -------------
    out_ready = 1'b1;
    send_bits("full", 32'h0000_008D, 8);
    check("full_valid", {31'd0, out_valid}, 32'd1);
    check("full_word",  {24'd0, out_word},  32'h8D);
    check("full_count", {28'd0, out_count}, 32'd8);
    tick();
    check("full_drain", {31'd0, out_valid}, 32'd0);

    // ---- 3. backpressure: 0xFF then 0x0F with out_ready low -------------
    out_ready = 1'b0;
    send_bits("bp", 32'h0000_0FFF, 16);
    check("bp_valid",  {31'd0, out_valid}, 32'd1);
    check("bp_word",   {24'd0, out_word},  32'hFF);
    check("bp_count",  {28'd0, out_count}, 32'd8);
    check("bp_stall",  {31'd0, in_ready},  32'd0);
    tick();
    tick();
    check("bp_stable", {24'd0, out_word},  32'hFF);
    check("bp_stall2", {31'd0, in_ready},  32'd0);
    out_ready = 1'b1;
    tick();
    check("bp_valid2", {31'd0, out_valid}, 32'd1);
    check("bp_word2",  {24'd0, out_word},  32'h0F);
    check("bp_count2", {28'd0, out_count}, 32'd8);
    check("bp_ready2", {31'd0, in_ready},  32'd1);
    tick();
    check("bp_drain",  {31'd0, out_valid}, 32'd0);

    // ---- 4a. flush after bits 1,1,0 -> 0x03 / 3 --------------------------
    send_bits("fl", 32'h0000_0003, 3);
    check("fl_novalid", {31'd0, out_valid}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", {31'd0, out_valid}, 32'd1);
    check("fl_word",  {24'd0, out_word},  32'h03);
    check("fl_count", {28'd0, out_count}, 32'd3);
    tick();

    // ---- 4b. flush with an empty accumulator leaves nothing pending -----
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fe_valid", {31'd0, out_valid}, 32'd0);
    send_bits("fe", 32'h0000_0001, 1);
    check("fe_nopend", {31'd0, out_valid}, 32'd0);
    send_bits("fe2", 32'h0000_007F, 7);
    check("fe_word",  {24'd0, out_word},  32'hFF);
    check("fe_count", {28'd0, out_count}, 32'd8);
    tick();

    // ---- 4c. flush while blocked becomes pending --------------------------
    out_ready = 1'b0;
    send_bits("fp", 32'h0000_00A5, 8);
    check("fp_word",  {24'd0, out_word}, 32'hA5);
    send_bits("fp2", 32'h0000_0001, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("fp_held",  {24'd0, out_word},  32'hA5);
    check("fp_hcnt",  {28'd0, out_count}, 32'd8);
    out_ready = 1'b1;
    tick();
    check("fp_valid", {31'd0, out_valid}, 32'd1);
    check("fp_word2", {24'd0, out_word},  32'h01);
    check("fp_count", {28'd0, out_count}, 32'd2);
    tick();
    check("fp_drain", {31'd0, out_valid}, 32'd0);

    // ---- 4d. flush coincident with an accepted bit includes it ----------
    send_bits("fc", 32'h0000_0001, 1);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    in_bit   = 1'b0;
    flush    = 1'b0;
    check("fc_word",  {24'd0, out_word},  32'h03);
    check("fc_count", {28'd0, out_count}, 32'd2);
    tick();

    // ---- 5. reset mid-word discards partial bits -------------------------
    send_bits("rm", 32'h0000_001F, 5);
    #2 areset = 1'b1;
    #1;
    check("rm_ready", {31'd0, in_ready},  32'd1);
    check("rm_valid", {31'd0, out_valid}, 32'd0);
    #1 areset = 1'b0;
    tick();
    send_bits("rm2", 32'h0000_0007, 3);
    check("rm_nostale", {31'd0, out_valid}, 32'd0);
    send_bits("rm3", 32'h0000_001F, 5);
    check("rm_word",  {24'd0, out_word},  32'hFF);
    check("rm_count", {28'd0, out_count}, 32'd8);
    tick();

`ifdef PARITY_ERRCNT_EN
    // ---- 6. saturating error counter -------------------------------------
    areset = 1'b1;
    #1;
    check("ec_rst0", {16'd0, err_count}, 32'd0);
    areset = 1'b0;
    tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    check("ec_sat", {16'd0, err_count}, 32'h0000_FFFF);
    #2 areset = 1'b1;
    #1;
    check("ec_rst", {16'd0, err_count}, 32'd0);
    areset = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
